// File: rtl/dmem_pkg.sv
// Shared types and helpers for the wait-state data memory.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int unsigned LAT_W     = 4;
    localparam int unsigned MAX_LANES = 16;

    // Byte access enables only the addressed lane; word access enables all lanes.
    function automatic logic [MAX_LANES-1:0] lane_mask(input logic is_byte, input logic [3:0] ofs);
        lane_mask = is_byte ? (MAX_LANES'(1) << ofs) : '1;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WIDTH storage with per-lane write enables and a registered read port.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 64,
    localparam int unsigned LANES = WIDTH / 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic [LANES-1:0] wen,
    input  logic             ren,
    input  logic [IDX_W-1:0] idx,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LANES); i++) begin
            if (wen[i]) begin
                mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (ren) begin
            q <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_ws.sv
// Wait-state data memory: req/ready handshake, fixed access latency, byte lanes,
// misaligned/out-of-range rejection.
module dmem_ws
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic              byte_sel,
    input  logic [ADDR_W-1:0] a,
    input  logic [WIDTH-1:0]  wd,
    output logic [WIDTH-1:0]  rd,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int unsigned LANES = WIDTH / 8;
    localparam int unsigned OFS   = $clog2(LANES);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    if (LATENCY > 15) begin : g_bad_latency
        $error("dmem_ws: LATENCY %0d outside 0..15", LATENCY);
    end
    if ((WIDTH % 8) != 0 || LANES < 2 || LANES > MAX_LANES) begin : g_bad_width
        $error("dmem_ws: WIDTH %0d unsupported", WIDTH);
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("dmem_ws: DEPTH %0d unsupported", DEPTH);
    end

    state_t            state, state_next;
    logic [LAT_W-1:0]  count, count_next;
    logic              ready_next, busy_next, err_next;
    logic              accept_c, commit_c;

    logic [ADDR_W-1:0] a_q;
    logic [WIDTH-1:0]  wd_q;
    logic              we_q, byte_q;

    logic [ADDR_W-1:0] src_a, word_addr;
    logic [WIDTH-1:0]  src_wd;
    logic              src_we, src_byte;
    logic [OFS-1:0]    lane_c;
    logic              bad_c, do_access;

    logic [LANES-1:0]  wen;
    logic              ren;
    logic [WIDTH-1:0]  wdata, q;

    logic              zero_q, rbyte_q;
    logic [OFS-1:0]    lane_q;

    // With zero latency the commit happens on the accept edge, so use live inputs.
    assign src_a    = (state == IDLE) ? a        : a_q;
    assign src_wd   = (state == IDLE) ? wd       : wd_q;
    assign src_we   = (state == IDLE) ? we       : we_q;
    assign src_byte = (state == IDLE) ? byte_sel : byte_q;

    assign lane_c    = src_a[OFS-1:0];
    assign word_addr = src_a >> OFS;
    assign bad_c     = (!src_byte && lane_c != '0) || (word_addr >= ADDR_W'(DEPTH));
    assign do_access = commit_c && reset && !bad_c;

    assign wen   = (do_access && src_we) ? LANES'(lane_mask(src_byte, 4'(lane_c))) : '0;
    assign ren   = do_access && !src_we;
    assign wdata = src_byte ? {LANES{src_wd[7:0]}} : src_wd;

    dmem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .wen   (wen),
        .ren   (ren),
        .idx   (src_a[OFS +: IDX_W]),
        .wdata (wdata),
        .q     (q)
    );

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_next = state;
        count_next = count;
        accept_c   = 1'b0;
        commit_c   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept_c = 1'b1;
                    if (LATENCY == 0) begin
                        state_next = DONE;
                        commit_c   = 1'b1;
                    end else begin
                        state_next = WAIT;
                        count_next = LAT_W'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (count == LAT_W'(1)) begin
                    state_next = DONE;
                    count_next = '0;
                    commit_c   = 1'b1;
                end else begin
                    count_next = count - LAT_W'(1);
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        ready_next = (state_next == DONE);
        busy_next  = (state_next != IDLE);
        err_next   = commit_c && bad_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            zero_q  <= 1'b1;
            rbyte_q <= 1'b0;
            lane_q  <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            ready <= ready_next;
            busy  <= busy_next;
            err   <= err_next;
            if (accept_c) begin
                a_q    <= a;
                wd_q   <= wd;
                we_q   <= we;
                byte_q <= byte_sel;
            end
            if (commit_c) begin
                zero_q  <= src_we || bad_c;
                rbyte_q <= src_byte;
                lane_q  <= lane_c;
            end
        end
    end

    // Read data is formed from registered state only and holds between completions.
    assign rd = zero_q  ? '0 :
                rbyte_q ? WIDTH'(8'(q >> {lane_q, 3'b000})) : q;

endmodule
